// File: rtl/bin32_bcd8.sv
// 32-bit binary to 8-digit packed BCD converter (double-dabble, one bit per clock)
// with leading-zero blanking mask and overflow flag for values above 99 999 999.
module bin32_bcd8 #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data,
  output logic        out_valid,
  output logic [31:0] bcd,
  output logic [7:0]  blank,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [39:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] bcd_q, bcd_d;
  logic [7:0]  blank_q, blank_d;
  logic        ovf_q, ovf_d;
  logic        out_valid_q, out_valid_d;

  logic [39:0] acc_adj_s;
  logic [71:0] shifted_s;
  logic        acc_ovf_s;

  function automatic logic [39:0] add3_digits(input logic [39:0] a);
    logic [39:0] r;
    r = a;
    for (int i = 0; i < 10; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Digit 0 never blanks, so only digits 7..1 are inspected.
  function automatic logic [7:0] blank_mask(input logic [27:0] d);
    logic [7:0] m;
    logic       zero_run;
    m        = 8'h00;
    zero_run = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      zero_run = zero_run & (d[4*(i-1) +: 4] == 4'd0);
      m[i]     = zero_run;
    end
    return m;
  endfunction

  // Datapath helpers: corrected accumulator, combined shift, overflow detect
  always_comb begin
    acc_adj_s = add3_digits(acc_q);
    shifted_s = {acc_adj_s, sr_q} << 1;
    acc_ovf_s = (acc_q[39:32] != 8'd0);
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    blank_d     = blank_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = data;
          acc_d   = 40'd0;
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        {acc_d, sr_d} = shifted_s;
        cnt_d         = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        ovf_d       = acc_ovf_s;
        if (acc_ovf_s) begin
          blank_d = 8'h00;
          bcd_d   = SATURATE ? 32'h9999_9999 : acc_q[31:0];
        end else begin
          blank_d = blank_mask(acc_q[31:4]);
          bcd_d   = acc_q[31:0];
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= 32'd0;
      acc_q       <= 40'd0;
      cnt_q       <= 5'd0;
      bcd_q       <= 32'd0;
      blank_q     <= 8'hFE;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = bcd_q;
  assign blank     = blank_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin32_bcd8.sv
// Self-checking bench for bin32_bcd8: table vectors, random values against an
// arithmetic decimal model, and hand sequences for throughput, ignored pulses, abort.
module tb_bin32_bcd8;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] data;
  logic        in_ready_s, in_ready_w;
  logic        out_valid_s, out_valid_w;
  logic [31:0] bcd_s, bcd_w;
  logic [7:0]  blank_s, blank_w;
  logic        ovf_s, ovf_w;

  int tests = 0;
  int fails = 0;

  bin32_bcd8 #(.SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .data(data), .out_valid(out_valid_s), .bcd(bcd_s), .blank(blank_s),
    .overflow(ovf_s)
  );

  bin32_bcd8 #(.SATURATE(1'b0)) dut_w (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .data(data), .out_valid(out_valid_w), .bcd(bcd_w), .blank(blank_w),
    .overflow(ovf_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_sat;
    logic [31:0] exp_wrap;
    logic [7:0]  exp_blank;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_bcd(input logic [31:0] v, input bit sat);
    longint unsigned x, low;
    logic [31:0] r;
    x = {32'd0, v};
    if (x >= 64'd100000000 && sat) return 32'h9999_9999;
    low = x % 64'd100000000;
    r = 32'd0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(low % 64'd10);
      low = low / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_blank(input logic [31:0] v);
    longint unsigned x, p;
    logic [7:0] m;
    x = {32'd0, v};
    m = 8'h00;
    if (x >= 64'd100000000) return m;
    p = 64'd10;
    for (int i = 1; i < 8; i++) begin
      if (x < p) m[i] = 1'b1;
      p = p * 64'd10;
    end
    return m;
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] es, input logic [31:0] ew,
                               input logic [7:0] eb, input logic eo);
    chk({tag, " bcd_sat"}, bcd_s, es);
    chk({tag, " bcd_wrap"}, bcd_w, ew);
    chk({tag, " blank"}, {24'd0, blank_s}, {24'd0, eb});
    chk({tag, " blank_wrap"}, {24'd0, blank_w}, {24'd0, eb});
    chk({tag, " overflow"}, {31'd0, ovf_s}, {31'd0, eo});
    chk({tag, " overflow_wrap"}, {31'd0, ovf_w}, {31'd0, eo});
  endtask

  // One full conversion from idle: latency, busy window, results, single-cycle pulse.
  task automatic do_convert(input string tag, input logic [31:0] d, input logic [31:0] es,
                            input logic [31:0] ew, input logic [7:0] eb, input logic eo);
    int lat;
    bit busy_bad;
    @(negedge clock);
    chk({tag, " ready_before"}, {31'd0, in_ready_s & in_ready_w}, 32'd1);
    in_valid = 1'b1;
    data     = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    data     = $urandom;
    lat      = -1;
    busy_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (out_valid_s && out_valid_w) begin
        lat = n;
        break;
      end
      if (in_ready_s || in_ready_w || out_valid_s || out_valid_w) busy_bad = 1'b1;
    end
    chk({tag, " latency"}, lat, 32'd33);
    chk({tag, " busy_window"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, " ready_in_valid_cycle"}, {31'd0, in_ready_s}, 32'd1);
    check_outputs(tag, es, ew, eb, eo);
    @(posedge clock);
    #1;
    chk({tag, " pulse_width"}, {31'd0, out_valid_s | out_valid_w}, 32'd0);
    check_outputs({tag, " hold"}, es, ew, eb, eo);
  endtask

  // Accept 12 345 678; either pulse in_valid at E+5/E+20, or reset at rst_at.
  task automatic run_pulses(input int rst_at);
    int seen;
    @(negedge clock);
    chk("pulse ready_before", {31'd0, in_ready_s}, 32'd1);
    in_valid = 1'b1;
    data     = 32'h00BC_614E;
    @(posedge clock);
    #1;
    seen = -1;
    for (int n = 1; n <= 40; n++) begin
      in_valid = (n == 5) || (rst_at == 0 && n == 20);
      data     = 32'd999;
      reset    = (n == rst_at);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      reset    = 1'b0;
      if (out_valid_s && seen < 0) begin
        seen = n;
        chk("pulse bcd", bcd_s, 32'h1234_5678);
        chk("pulse overflow", {31'd0, ovf_s}, 32'd0);
      end
      if (n == rst_at) begin
        check_outputs("abort", 32'd0, 32'd0, 8'hFE, 1'b0);
        chk("abort out_valid", {31'd0, out_valid_s | out_valid_w}, 32'd0);
        chk("abort ready", {31'd0, in_ready_s & in_ready_w}, 32'd1);
      end
    end
    if (rst_at == 0) chk("pulse latency", seen, 32'd33);
    else chk("abort no_out_valid", seen, -32'sd1);
  endtask

  initial begin
    logic [31:0] v;
    int          ready_cyc[$];
    int          cyc;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 8'hFE, 1'b0};
    vecs[1] = '{32'h00BC_614E, 32'h1234_5678, 32'h1234_5678, 8'h00, 1'b0};
    vecs[2] = '{32'd42,        32'h0000_0042, 32'h0000_0042, 8'hFC, 1'b0};
    vecs[3] = '{32'h05F5_E0FF, 32'h9999_9999, 32'h9999_9999, 8'h00, 1'b0};
    vecs[4] = '{32'h05F5_E100, 32'h9999_9999, 32'h0000_0000, 8'h00, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h9999_9999, 32'h9496_7295, 8'h00, 1'b1};
    vecs[6] = '{32'd1,         32'h0000_0001, 32'h0000_0001, 8'hFE, 1'b0};
    vecs[7] = '{32'd1000,      32'h0000_1000, 32'h0000_1000, 8'hF0, 1'b0};

    reset    = 1'b1;
    in_valid = 1'b0;
    data     = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset in_ready", {31'd0, in_ready_s & in_ready_w}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid_s | out_valid_w}, 32'd0);
    check_outputs("reset", 32'd0, 32'd0, 8'hFE, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_convert($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_sat, vecs[i].exp_wrap,
                 vecs[i].exp_blank, vecs[i].exp_ovf);
    end

    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 99999999);
        default: v = $urandom_range(0, 9999);
      endcase
      do_convert($sformatf("rand%0d_%h", i, v), v, model_bcd(v, 1'b1), model_bcd(v, 1'b0),
                 model_blank(v), (v >= 32'd100000000));
    end

    // Back-to-back throughput with in_valid held high.
    @(negedge clock);
    in_valid = 1'b1;
    data     = 32'h00BC_614E;
    cyc      = 0;
    for (int k = 0; k < 150 && ready_cyc.size() < 3; k++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (in_ready_s) begin
        ready_cyc.push_back(cyc);
        chk("b2b out_valid", {31'd0, out_valid_s}, 32'd1);
        chk("b2b bcd", bcd_s, 32'h1234_5678);
      end
    end
    in_valid = 1'b0;
    chk("b2b accepts", ready_cyc.size(), 32'd3);
    if (ready_cyc.size() == 3) begin
      chk("b2b first", ready_cyc[0], 32'd34);
      chk("b2b spacing1", ready_cyc[1] - ready_cyc[0], 32'd34);
      chk("b2b spacing2", ready_cyc[2] - ready_cyc[1], 32'd34);
    end

    run_pulses(0);
    run_pulses(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
